aes_sub_bytes_pipe: RTL and testbench

Pipelined, parametrised AES SubBytes/InvSubBytes engine. It applies the Rijndael inverse S-box, and optionally the forward S-box, to NBYTES bytes in parallel behind a valid/ready handshake with a configurable register depth. It sits between the round-key/state datapath and the MixColumns stage in the round pipeline. It also serves the key-expansion path with NBYTES=4, and the full-state path with NBYTES=16.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_inv_sbox.sv | 36 +++
 rtl/aes_sbox.sv | 36 +++
 rtl/aes_sub_bytes_lane.sv | 39 +++
 rtl/aes_sub_bytes_pipe.sv | 144 ++++++++++++++
 tb/tb_aes_sub_bytes_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package : aes_pkg
// Brief   : Shared byte type and legal configuration limits for the S-box pipe.
// Rev     : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BYTE_W = 8;

  typedef logic [AES_BYTE_W-1:0] aes_byte_t;

  localparam int AES_NBYTES_MIN = 1;
  localparam int AES_NBYTES_MAX = 16;
  localparam int AES_STAGES_MIN = 1;
  localparam int AES_STAGES_MAX = 3;
  localparam int AES_TAG_W_MIN  = 1;
  localparam int AES_TAG_W_MAX  = 16;

  function automatic bit aes_cfg_legal(input int nbytes, input int stages, input int tag_w);
    return (nbytes >= AES_NBYTES_MIN) && (nbytes <= AES_NBYTES_MAX) &&
           (stages >= AES_STAGES_MIN) && (stages <= AES_STAGES_MAX) &&
           (tag_w  >= AES_TAG_W_MIN)  && (tag_w  <= AES_TAG_W_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module : aes_inv_sbox
// Brief  : Rijndael inverse S-box, single byte, combinational table lookup.
// Rev    : 1.0 - initial release
// ============================================================================
module aes_inv_sbox
  import aes_pkg::*;
(
  input  aes_byte_t byte_i,
  output aes_byte_t byte_o
);

  localparam aes_byte_t C_INV_SBOX_TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign byte_o = C_INV_SBOX_TBL[byte_i];

endmodule
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module : aes_sbox
// Brief  : Rijndael forward S-box, single byte, combinational table lookup.
// Rev    : 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_pkg::*;
(
  input  aes_byte_t byte_i,
  output aes_byte_t byte_o
);

  localparam aes_byte_t C_SBOX_TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign byte_o = C_SBOX_TBL[byte_i];

endmodule
`default_nettype wire

// File: rtl/aes_sub_bytes_lane.sv
`default_nettype none
// ============================================================================
// Module : aes_sub_bytes_lane
// Brief  : One combinational SubBytes lane; inverse only, or forward/inverse
//          muxed per beat when AES_SBOX_FWD_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module aes_sub_bytes_lane
  import aes_pkg::*;
(
  input  aes_byte_t byte_i,
`ifdef AES_SBOX_FWD_EN
  input  logic      inv_i,
`endif
  output aes_byte_t byte_o
);

  aes_byte_t w_inv_byte;

  aes_inv_sbox u_inv_sbox (
    .byte_i (byte_i),
    .byte_o (w_inv_byte)
  );

`ifdef AES_SBOX_FWD_EN
  aes_byte_t w_fwd_byte;

  aes_sbox u_fwd_sbox (
    .byte_i (byte_i),
    .byte_o (w_fwd_byte)
  );

  assign byte_o = inv_i ? w_inv_byte : w_fwd_byte;
`else
  assign byte_o = w_inv_byte;
`endif

endmodule
`default_nettype wire

// File: rtl/aes_sub_bytes_pipe.sv
`default_nettype none
// ============================================================================
// Module : aes_sub_bytes_pipe
// Brief  : NBYTES-lane SubBytes engine behind an elastic STAGES-deep pipeline.
//          Define AES_SBOX_FWD_EN to add the per-beat forward S-box (in_inv).
// Rev    : 1.0 - initial release
// ============================================================================
module aes_sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [AES_BYTE_W*NBYTES-1:0] in_data,
`ifdef AES_SBOX_FWD_EN
  input  logic                         in_inv,
`endif
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AES_BYTE_W*NBYTES-1:0] out_data,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         busy
);

  localparam int DATA_W = AES_BYTE_W * NBYTES;

  if (!aes_cfg_legal(NBYTES, STAGES, TAG_W)) begin : g_cfg_check
    $error("aes_sub_bytes_pipe: illegal NBYTES=%0d STAGES=%0d TAG_W=%0d", NBYTES, STAGES, TAG_W);
  end

  logic [DATA_W-1:0] w_sub_data;

  for (genvar k = 0; k < NBYTES; k++) begin : g_lane
    aes_sub_bytes_lane u_lane (
      .byte_i (in_data[AES_BYTE_W*k +: AES_BYTE_W]),
`ifdef AES_SBOX_FWD_EN
      .inv_i  (in_inv),
`endif
      .byte_o (w_sub_data[AES_BYTE_W*k +: AES_BYTE_W])
    );
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
`ifdef AES_SBOX_FWD_EN
  logic [STAGES-1:0] inv_q;
  logic [STAGES-1:0] inv_d;
`endif

  logic [STAGES:0]   w_rdy;
  logic [STAGES-1:0] w_src_v;
  logic [DATA_W-1:0] w_src_data [STAGES];
  logic [TAG_W-1:0]  w_src_tag  [STAGES];
`ifdef AES_SBOX_FWD_EN
  logic [STAGES-1:0] w_src_inv;
`endif

  // A stage may load whenever it is empty or its successor is loading too.
  always_comb begin
    w_rdy[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      w_rdy[s] = ~v_q[s] | w_rdy[s+1];
    end
  end

  always_comb begin
    w_src_v[0]    = in_valid;
    w_src_data[0] = w_sub_data;
    w_src_tag[0]  = in_tag;
`ifdef AES_SBOX_FWD_EN
    w_src_inv[0]  = in_inv;
`endif
    for (int s = 1; s < STAGES; s++) begin
      w_src_v[s]    = v_q[s-1];
      w_src_data[s] = data_q[s-1];
      w_src_tag[s]  = tag_q[s-1];
`ifdef AES_SBOX_FWD_EN
      w_src_inv[s]  = inv_q[s-1];
`endif
    end
  end

  // Payload registers only capture real beats, so bubbles leave them untouched.
  always_comb begin
    v_d = v_q;
`ifdef AES_SBOX_FWD_EN
    inv_d = inv_q;
`endif
    for (int s = 0; s < STAGES; s++) begin
      data_d[s] = data_q[s];
      tag_d[s]  = tag_q[s];
      if (w_rdy[s]) begin
        v_d[s] = w_src_v[s];
        if (w_src_v[s]) begin
          data_d[s] = w_src_data[s];
          tag_d[s]  = w_src_tag[s];
`ifdef AES_SBOX_FWD_EN
          inv_d[s]  = w_src_inv[s];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
`ifdef AES_SBOX_FWD_EN
      inv_q <= '0;
`endif
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        tag_q[s]  <= '0;
      end
    end else begin
      v_q <= v_d;
`ifdef AES_SBOX_FWD_EN
      inv_q <= inv_d;
`endif
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= data_d[s];
        tag_q[s]  <= tag_d[s];
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign busy      = |v_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_sub_bytes_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_sub_bytes_pipe
// Brief  : Scoreboard bench for two configurations (4 lanes/2 stages and
//          16 lanes/3 stages) against a GF(2^8) S-box model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_aes_sub_bytes_pipe;

  localparam int A_NB = 4;
  localparam int A_ST = 2;
  localparam int A_TW = 4;
  localparam int B_NB = 16;
  localparam int B_ST = 3;
  localparam int B_TW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              a_in_valid = 1'b0, a_in_ready, a_in_inv = 1'b1;
  logic [8*A_NB-1:0] a_in_data = '0, a_out_data;
  logic [A_TW-1:0]   a_in_tag = '0, a_out_tag;
  logic              a_out_valid, a_out_ready = 1'b0, a_busy;

  logic              b_in_valid = 1'b0, b_in_ready, b_in_inv = 1'b1;
  logic [8*B_NB-1:0] b_in_data = '0, b_out_data;
  logic [B_TW-1:0]   b_in_tag = '0, b_out_tag;
  logic              b_out_valid, b_out_ready = 1'b0, b_busy;

  aes_sub_bytes_pipe #(.NBYTES(A_NB), .STAGES(A_ST), .TAG_W(A_TW)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
`ifdef AES_SBOX_FWD_EN
    .in_inv(a_in_inv),
`endif
    .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag), .busy(a_busy)
  );

  aes_sub_bytes_pipe #(.NBYTES(B_NB), .STAGES(B_ST), .TAG_W(B_TW)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
`ifdef AES_SBOX_FWD_EN
    .in_inv(b_in_inv),
`endif
    .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag), .busy(b_busy)
  );

`ifdef AES_SBOX_FWD_EN
  wire a_inv_eff = a_in_inv;
  wire b_inv_eff = b_in_inv;
`else
  wire a_inv_eff = 1'b1;
  wire b_inv_eff = 1'b1;
`endif

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference S-boxes built from the field inverse and the affine transform.
  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, a, b;
    p = 8'h00; a = x; b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_model();
    logic [7:0] xi, bb, s;
    for (int x = 0; x < 256; x++) begin
      xi = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
      bb = xi;
      s = bb ^ {bb[6:0], bb[7]} ^ {bb[5:0], bb[7:6]} ^ {bb[4:0], bb[7:5]} ^ {bb[3:0], bb[7:4]} ^ 8'h63;
      m_fwd[x] = s;
      m_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_sub(input logic [127:0] d, input int nb, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < nb; k++)
      r[8*k +: 8] = inv ? m_inv[d[8*k +: 8]] : m_fwd[d[8*k +: 8]];
    return r;
  endfunction

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  t;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e, b_e;
  bit   b_lat_arm = 1'b0;
  int   b_first_out = 0;
  bit   b_rand = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) a_q.delete();
    else begin
      if (a_out_valid && a_q.size() == 0) check("a_spurious", 128'(a_out_valid), 128'd0);
      else if (a_out_valid) begin
        check("a_data", 128'(a_out_data), a_q[0].d);
        check("a_tag", 128'(a_out_tag), 128'(a_q[0].t));
        if (a_out_ready) void'(a_q.pop_front());
      end
      if (a_in_valid && a_in_ready) begin
        a_e.d = model_sub(128'(a_in_data), A_NB, a_inv_eff);
        a_e.t = 16'(a_in_tag);
        a_q.push_back(a_e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) b_q.delete();
    else begin
      if (b_out_valid && b_lat_arm) begin
        b_first_out = cyc;
        b_lat_arm = 1'b0;
      end
      if (b_out_valid && b_q.size() == 0) check("b_spurious", 128'(b_out_valid), 128'd0);
      else if (b_out_valid) begin
        check("b_data", b_out_data, b_q[0].d);
        check("b_tag", 128'(b_out_tag), 128'(b_q[0].t));
        if (b_out_ready) void'(b_q.pop_front());
      end
      if (b_in_valid && b_in_ready) begin
        b_e.d = model_sub(b_in_data, B_NB, b_inv_eff);
        b_e.t = b_in_tag;
        b_q.push_back(b_e);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (b_rand) b_out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_a(input logic [31:0] d, input logic [3:0] t, input logic inv);
    bit ok;
    ok = 1'b0;
    a_in_data = d; a_in_tag = t; a_in_inv = inv; a_in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    if (!ok) check("a_accept_timeout", 128'(ok), 128'd1);
  endtask

  task automatic send_b(input logic [127:0] d, input logic [15:0] t, input logic inv, output int acc);
    bit ok;
    ok = 1'b0; acc = -1;
    b_in_data = d; b_in_tag = t; b_in_inv = inv; b_in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (b_in_ready) begin ok = 1'b1; acc = cyc; break; end
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    if (!ok) check("b_accept_timeout", 128'(ok), 128'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (a_q.size() == 0 && b_q.size() == 0 && !a_out_valid && !b_out_valid) begin idle = 1'b1; break; end
    end
    check(tag, 128'(idle), 128'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, first_acc, last_acc, took, acc_cyc;
    bit seen;
    logic [127:0] d;

    build_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("a_rst_valid", 128'(a_out_valid), 128'd0);
    check("a_rst_data", 128'(a_out_data), 128'd0);
    check("a_rst_tag", 128'(a_out_tag), 128'd0);
    check("a_rst_busy", 128'(a_busy), 128'd0);
    check("a_rst_in_ready", 128'(a_in_ready), 128'd1);
    check("b_rst_valid", 128'(b_out_valid), 128'd0);
    check("b_rst_data", b_out_data, 128'd0);
    check("b_rst_busy", 128'(b_busy), 128'd0);
    check("b_rst_in_ready", 128'(b_in_ready), 128'd1);
    @(posedge clk); #1;

    // Directed vector with explicit latency check on the 2-stage instance.
    a_out_ready = 1'b1;
    a_in_data = 32'h637C1600; a_in_tag = 4'h5; a_in_inv = 1'b1; a_in_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    check("a_dir_accept", 128'(a_in_ready), 128'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (a_out_valid) begin seen = 1'b1; break; end
    end
    check("a_dir_seen", 128'(seen), 128'd1);
    check("a_dir_latency", 128'(cyc - acc_cyc), 128'(A_ST));
    check("a_dir_data", 128'(a_out_data), 128'h0001FF52);
    check("a_dir_tag", 128'(a_out_tag), 128'h5);
    wait_idle("a_dir_drain");
    @(posedge clk); #1;

    // Stall with in_valid held: only STAGES beats may enter.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = $urandom; a_in_tag = 4'h1;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      took = int'(a_in_ready);
      if (took != 0) acc++;
      @(posedge clk); #1;
      if (took != 0) begin a_in_data = $urandom; a_in_tag = a_in_tag + 4'd1; end
    end
    check("a_stall_accepts", 128'(acc), 128'd2);
    check("a_stall_in_ready", 128'(a_in_ready), 128'd0);
    check("a_stall_busy", 128'(a_busy), 128'd1);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    wait_idle("a_stall_drain");
    @(negedge clk);
    check("a_stall_busy_after", 128'(a_busy), 128'd0);
    @(posedge clk); #1;

`ifdef AES_SBOX_FWD_EN
    send_a(32'h00000000, 4'h1, 1'b0);
    send_a(32'h63636363, 4'h2, 1'b1);
    send_a(32'h53535353, 4'h3, 1'b0);
    wait_idle("a_fwd_drain");
    @(posedge clk); #1;
`endif

    // Every byte value in every lane, back to back, out_ready held high.
    b_out_ready = 1'b1;
    b_lat_arm = 1'b1;
    first_acc = 0; last_acc = 0;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < B_NB; k++) d[8*k +: 8] = 8'(i + 17 * k);
      send_b(d, 16'(i), 1'b1, acc);
      if (i == 0) first_acc = acc;
      if (i == 255) last_acc = acc;
    end
    check("b_throughput", 128'(last_acc - first_acc), 128'd255);
    wait_idle("b_sweep_drain");
    check("b_first_latency", 128'(b_first_out - first_acc), 128'(B_ST));
    @(posedge clk); #1;

    // Random backpressure and gaps; tags increment so any loss or repeat shows.
    b_rand = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      d = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_SBOX_FWD_EN
      send_b(d, 16'(i), 1'($urandom_range(0, 1)), acc);
`else
      send_b(d, 16'(i), 1'b1, acc);
`endif
    end
    b_rand = 1'b0;
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    wait_idle("b_rand_drain");
    @(posedge clk); #1;

    // Fill the pipe, then reset asynchronously with three beats in flight.
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_b({4{$urandom}}, 16'(16'hA000 + i), 1'b1, acc);
    check("b_full_busy", 128'(b_busy), 128'd1);
    check("b_full_in_ready", 128'(b_in_ready), 128'd0);
    #2 rst_n = 1'b0;
    #1;
    check("b_arst_valid", 128'(b_out_valid), 128'd0);
    check("b_arst_busy", 128'(b_busy), 128'd0);
    check("b_arst_data", b_out_data, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b_out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("b_post_rst_valid", 128'(b_out_valid), 128'd0);
    check("b_post_rst_queue", 128'(b_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
